// File: rtl/m10k_stream_reader.sv
// Streams a contiguous M10K address range out on a valid/ready interface.
// Reads are issued against a credit of 4 words so backpressure never drops data.
module m10k_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 19
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] st_data,
   output logic                  st_valid,
   input  logic                  st_ready,
   output logic                  st_sop,
   output logic                  st_eop,
   output logic [1:0]            fsm_state
);

   // Handshake: a word transfers on every clk edge where st_valid & st_ready;
   // once st_valid rises, st_data/st_sop/st_eop hold until that transfer happens.

   localparam int TW = DATA_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0]   ONE_CNT  = 1;
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = 1;
   localparam logic [2:0]            ONE3     = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [ADDR_WIDTH:0] len_q, issued;
   logic                issue, issue_sop, issue_eop;
   logic                pend1, pend2;
   logic [1:0]          tag1, tag2;

   logic [TW-1:0] fifo_mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fifo_cnt;

   logic          out_valid;
   logic [TW-1:0] out_word;

   logic          handshake, load_ok, from_fifo, from_cap, fifo_push, credit;
   logic [2:0]    occ;
   logic [TW-1:0] cap_word;

   // Words held plus reads whose data has not yet been captured.
   assign occ       = {2'b00, out_valid} + fifo_cnt + {2'b00, pend1} + {2'b00, pend2};
   assign credit    = occ < 3'd4;
   assign handshake = out_valid & st_ready;
   assign load_ok   = ~out_valid | handshake;
   assign from_fifo = load_ok & (fifo_cnt != 3'd0);
   assign from_cap  = load_ok & (fifo_cnt == 3'd0) & pend2;
   assign fifo_push = pend2 & ~from_cap;
   assign cap_word  = {rdata, tag2};

   always_comb begin
      state_nx  = state;
      issue     = 1'b0;
      issue_sop = 1'b0;
      issue_eop = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_nx = FINISH;
               end else begin
                  issue     = 1'b1;
                  issue_sop = 1'b1;
                  issue_eop = (length == ONE_CNT);
                  state_nx  = (length == ONE_CNT) ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            if (credit) begin
               issue     = 1'b1;
               issue_eop = ((issued + ONE_CNT) == len_q);
               if (issue_eop) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (handshake && out_word[0]) state_nx = FINISH;
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         len_q     <= '0;
         issued    <= '0;
         raddr     <= '0;
         pend1     <= 1'b0;
         pend2     <= 1'b0;
         tag1      <= 2'b00;
         tag2      <= 2'b00;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         fifo_cnt  <= 3'd0;
         out_valid <= 1'b0;
         out_word  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) len_q <= length;

         if (issue) begin
            if (state == IDLE) begin
               raddr  <= base_addr;
               issued <= ONE_CNT;
            end else begin
               raddr  <= raddr + ONE_ADDR;
               issued <= issued + ONE_CNT;
            end
         end else if (state == DRAIN && pend1 && tag1[0]) begin
            // Step past the last read so a full sweep leaves raddr at base_addr.
            raddr <= raddr + ONE_ADDR;
         end

         pend1 <= issue;
         tag1  <= {issue_sop, issue_eop};
         pend2 <= pend1;
         tag2  <= tag1;

         if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
         if (from_fifo) rd_ptr <= rd_ptr + 2'd1;
         case ({fifo_push, from_fifo})
            2'b10:   fifo_cnt <= fifo_cnt + ONE3;
            2'b01:   fifo_cnt <= fifo_cnt - ONE3;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (from_fifo) begin
            out_word  <= fifo_mem[rd_ptr];
            out_valid <= 1'b1;
         end else if (from_cap) begin
            out_word  <= cap_word;
            out_valid <= 1'b1;
         end else if (handshake) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= cap_word;
   end

   assign busy      = (state != IDLE);
   assign done      = (state == FINISH);
   assign st_valid  = out_valid;
   assign st_data   = out_word[TW-1:2];
   assign st_sop    = out_valid & out_word[1];
   assign st_eop    = out_valid & out_word[0];
   assign fsm_state = state;

endmodule

// File: tb/tb_m10k_stream_reader.sv
// Directed bench for m10k_stream_reader: a 19-bit instance for normal, stall,
// reset and start-storm cases, and a 4-bit instance for address wrap.
module tb_m10k_stream_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, busy, done, st_valid, st_ready, st_sop, st_eop;
   logic [18:0] base_addr, raddr;
   logic [19:0] length;
   logic [7:0]  rdata, st_data;
   logic [1:0]  fsm_state;

   logic        b_start, b_busy, b_done, b_st_valid, b_ready, b_sop, b_eop;
   logic [3:0]  b_base, b_raddr;
   logic [4:0]  b_len;
   logic [7:0]  b_rdata, b_st_data;
   logic [1:0]  b_fsm_state;

   m10k_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(19)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .raddr(raddr), .rdata(rdata),
      .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
      .st_sop(st_sop), .st_eop(st_eop), .fsm_state(fsm_state)
   );

   m10k_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .base_addr(b_base),
      .length(b_len), .busy(b_busy), .done(b_done), .raddr(b_raddr), .rdata(b_rdata),
      .st_data(b_st_data), .st_valid(b_st_valid), .st_ready(b_ready),
      .st_sop(b_sop), .st_eop(b_eop), .fsm_state(b_fsm_state)
   );

   // RAM models: word i holds i[7:0], read data one cycle after the address.
   always @(posedge clk) rdata   <= raddr[7:0];
   always @(posedge clk) b_rdata <= {4'h0, b_raddr};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0, failed = 0, total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- ready driver ----------------
   int ready_mode = 0;
   int stall_left = 0;
   initial begin
      st_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: st_ready = 1'b1;
            1: begin
               if (stall_left > 0) begin
                  st_ready = 1'b0;
                  stall_left--;
               end else if ($urandom_range(0, 9) == 0) begin
                  st_ready   = 1'b0;
                  stall_left = 4;
               end else begin
                  st_ready = ~st_ready;
               end
            end
            default: st_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitors ----------------
   int         base_cyc = 0, b_base_cyc = 0;
   logic [7:0] got_data[$];
   logic       got_sop[$], got_eop[$];
   int         got_cyc[$];
   int         done_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [9:0] hold_word;

   always @(negedge clk) begin
      if (reset_n) begin
         if (stall_prev) begin
            check("hold_valid", st_valid, 1);
            check("hold_word", {st_sop, st_eop, st_data}, hold_word);
         end
         if (st_valid && st_ready) begin
            got_data.push_back(st_data);
            got_sop.push_back(st_sop);
            got_eop.push_back(st_eop);
            got_cyc.push_back(cyc - base_cyc + 1);
         end
         if (done) done_cnt++;
         stall_prev = st_valid && !st_ready;
         hold_word  = {st_sop, st_eop, st_data};
      end else begin
         stall_prev = 1'b0;
      end
   end

   logic [7:0] b_data_q[$];
   logic       b_sop_q[$], b_eop_q[$];
   logic [3:0] b_raddr_q[$];
   int         b_done_cnt = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (b_busy) b_raddr_q.push_back(b_raddr);
         if (b_st_valid && b_ready) begin
            b_data_q.push_back(b_st_data);
            b_sop_q.push_back(b_sop);
            b_eop_q.push_back(b_eop);
         end
         if (b_done) b_done_cnt++;
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic clear_a();
      got_data.delete();
      got_sop.delete();
      got_eop.delete();
      got_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic start_a(input logic [18:0] base, input logic [19:0] len);
      start     = 1'b1;
      base_addr = base;
      length    = len;
      tick();
      base_cyc = cyc;
      start    = 1'b0;
   endtask

   task automatic wait_done_a(input string tag, input int budget, input int exp_cyc);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_done"}, done, 1);
      if (exp_cyc > 0) check({tag, "_done_cyc"}, cyc - base_cyc + 1, exp_cyc);
      tick();
      check({tag, "_busy_low"}, busy, 0);
   endtask

   task automatic check_stream(input string tag, input logic [7:0] base, input int len,
                               input bit chk_cyc);
      logic [7:0] exp_q[$];
      logic [7:0] e;
      for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(i));
      check({tag, "_beats"}, got_data.size(), len);
      for (int i = 0; i < got_data.size() && i < len; i++) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, got_data[i], e);
         check({tag, "_sop"}, got_sop[i], (i == 0));
         check({tag, "_eop"}, got_eop[i], (i == len - 1));
         if (chk_cyc) check({tag, "_beat_cyc"}, got_cyc[i], 3 + i);
      end
   endtask

   task automatic run_b(input string tag, input logic [3:0] base, input logic [4:0] len,
                        input int exp_cyc, input bit chk_end);
      int n = 0;
      logic [3:0] a;
      b_data_q.delete();
      b_sop_q.delete();
      b_eop_q.delete();
      b_raddr_q.delete();
      b_done_cnt = 0;
      b_start = 1'b1;
      b_base  = base;
      b_len   = len;
      tick();
      b_base_cyc = cyc;
      b_start    = 1'b0;
      while (!b_done && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_done"}, b_done, 1);
      check({tag, "_done_cyc"}, cyc - b_base_cyc + 1, exp_cyc);
      tick();
      check({tag, "_busy_low"}, b_busy, 0);
      check({tag, "_done_cnt"}, b_done_cnt, 1);
      if (chk_end) check({tag, "_end_raddr"}, b_raddr, base);
      check({tag, "_beats"}, b_data_q.size(), len);
      for (int i = 0; i < int'(len) && i < b_raddr_q.size(); i++) begin
         a = base + 4'(i);
         check({tag, "_raddr"}, b_raddr_q[i], a);
      end
      for (int i = 0; i < int'(len) && i < b_data_q.size(); i++) begin
         a = base + 4'(i);
         check({tag, "_data"}, b_data_q[i], {4'h0, a});
         check({tag, "_sop"}, b_sop_q[i], (i == 0));
         check({tag, "_eop"}, b_eop_q[i], (i == int'(len) - 1));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      b_start   = 1'b0;
      b_base    = '0;
      b_len     = '0;
      b_ready   = 1'b1;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", st_valid, 0);
      check("rst_sop", st_sop, 0);
      check("rst_eop", st_eop, 0);
      check("rst_raddr", raddr, 0);
      check("rst_data", st_data, 0);
      check("rst_b_valid", b_st_valid, 0);
      reset_n = 1'b1;
      tick();

      // basic 8-word transfer, sink always ready
      clear_a();
      start_a(19'h10, 20'd8);
      check("t1_busy_c1", busy, 1);
      check("t1_raddr_c1", raddr, 19'h10);
      wait_done_a("t1", 40, 11);
      check("t1_done_cnt", done_cnt, 1);
      check_stream("t1", 8'h10, 8, 1);

      // same transfer with toggling ready and random stalls
      clear_a();
      ready_mode = 1;
      start_a(19'h10, 20'd8);
      wait_done_a("t2", 300, 0);
      ready_mode = 0;
      check("t2_done_cnt", done_cnt, 1);
      check_stream("t2", 8'h10, 8, 0);

      // zero length
      clear_a();
      start_a(19'h33, 20'd0);
      check("t3_busy_c1", busy, 1);
      check("t3_valid_c1", st_valid, 0);
      wait_done_a("t3", 5, 1);
      check("t3_done_c2", done, 0);
      repeat (3) tick();
      check("t3_beats", got_data.size(), 0);
      check("t3_done_cnt", done_cnt, 1);

      // single word: sop and eop together
      clear_a();
      start_a(19'h07, 20'd1);
      wait_done_a("t4", 20, 4);
      check_stream("t4", 8'h07, 1, 1);

      // reset with words backed up in the buffer
      clear_a();
      ready_mode = 2;
      start_a(19'h40, 20'd8);
      repeat (4) tick();
      check("t5_valid_before", st_valid, 1);
      reset_n = 1'b0;
      tick();
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_valid", st_valid, 0);
      check("t5_sop", st_sop, 0);
      check("t5_eop", st_eop, 0);
      check("t5_raddr", raddr, 0);
      check("t5_data", st_data, 0);
      reset_n    = 1'b1;
      ready_mode = 0;
      tick();
      check("t5_done_after", done, 0);
      check("t5_busy_after", busy, 0);
      tick();
      check("t5_beats_none", got_data.size(), 0);
      check("t5_done_cnt", done_cnt, 0);
      clear_a();
      start_a(19'h20, 20'd4);
      wait_done_a("t5b", 30, 7);
      check_stream("t5b", 8'h20, 4, 1);

      // start held high for the whole 16-word transfer
      clear_a();
      start     = 1'b1;
      base_addr = 19'h80;
      length    = 20'd16;
      tick();
      base_cyc  = cyc;
      base_addr = 19'h55;
      length    = 20'd3;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      start = 1'b0;
      check("t6_done", done, 1);
      check("t6_done_cyc", cyc - base_cyc + 1, 19);
      tick();
      check("t6_busy_low", busy, 0);
      repeat (2) tick();
      check("t6_no_restart", busy, 0);
      check("t6_done_cnt", done_cnt, 1);
      check_stream("t6", 8'h80, 16, 1);

      // 4-bit address space: wrap and full sweep
      run_b("t7", 4'hE, 5'd4, 7, 0);
      run_b("t8", 4'h5, 5'd16, 19, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
